alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Sequential execute stage that wraps the filter processor's combinational ALU.
- Accepts decoded operations from the operand-fetch stage over a valid/ready handshake and drives registered, stable operands onto the ALU inputs.
- Waits the op-dependent latency, captures the ALU result and compare flag, and presents them to writeback over a second valid/ready handshake.
- Owns the architectural compare-flag register used by conditional branches.

Parameters:
- DATA_W, 32, operand/result width; matches the ALU.
- DEST_W, 4, destination register index width.
- MUL_LAT, 2, extra EXEC cycles for multiply (code 4'b0010); legal range 0..7.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream operation valid.
- in_ready  out  1  stage can accept an operation this cycle.
- in_code  in  4  ALU opcode.
- in_x  in  DATA_W  operand X.
- in_y  in  DATA_W  operand Y.
- in_dest  in  DEST_W  destination register index.
- alu_code  out  4  to ALU code input (registered).
- alu_x  out  DATA_W  to ALU X (registered).
- alu_y  out  DATA_W  to ALU Y (registered).
- alu_z  in  DATA_W  from ALU Z.
- alu_cmp  in  1  from ALU CMP_Flag.
- out_valid  out  1  result valid to writeback.
- out_ready  in  1  writeback accepts the result.
- out_data  out  DATA_W  captured result.
- out_dest  out  DEST_W  captured destination.
- out_we  out  1  register-file write enable for this result.
- cmp_flag  out  1  architectural compare flag.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state IDLE, out_valid 0, out_data 0, out_dest 0, out_we 0, cmp_flag 0;
  - alu_code 4'b1111 (NOP), alu_x 0, alu_y 0, cycle counter 0.
- Reset mid-operation abandons the operation with no output.
- Opcode classes:
  - writing ops 4'b0000..4'b1001;
  - compare ops 4'b1010 (less-than) and 4'b1011 (equal);
  - NOP 4'b1100..4'b1111.
- FSM states: IDLE, EXEC, HOLD.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). It is purely combinational from state and out_ready.
- Accept occurs on an edge where in_valid && in_ready:
  - latch in_code/in_x/in_y/in_dest into alu_code/alu_x/alu_y/dest register;
  - load counter = MUL_LAT if in_code==4'b0010, else 0;
  - next state EXEC.
- EXEC:
  - ALU inputs stay constant for the whole state; in_ready=0 and in_valid is ignored (upstream holds).
  - If counter != 0: decrement and stay in EXEC.
  - If counter == 0: capture into the output registers and go to HOLD. The capture is:
    - out_data = alu_z if writing op, else 0;
    - out_we = 1 only for writing ops;
    - out_dest = dest register;
    - cmp_flag <= alu_cmp only for compare ops, otherwise unchanged;
    - out_valid <= 1;
    - alu_code <= 4'b1111.
- Latency: out_valid is high in the cycle after 1 + (MUL_LAT for multiply, else 0) edges following the accept edge. For non-mul: accept at edge k, capture at edge k+1, out_valid high after edge k+1.
- HOLD:
  - out_valid=1; out_data/out_dest/out_we remain stable while out_ready=0.
  - On an edge with out_ready=1 and a simultaneous accept: new op latched, state EXEC, out_valid cleared.
  - On an edge with out_ready=1 and no accept: state IDLE, out_valid cleared.
  - Peak throughput is one op per 2 cycles for non-mul ops.
- cmp_flag holds its value across non-compare ops, NOPs, and stalls. It is sampled only at the EXEC capture edge, never while the ALU inputs are changing.
- No counter wrap: counter only loads 0..MUL_LAT and decrements to 0.

Test Plan:
- Add: accept code 0000, X=5, Y=7, dest=3; out_ready=1 → next cycle out_valid=1, out_data=12, out_dest=3, out_we=1; cmp_flag unchanged (0).
- Multiply with MUL_LAT=2: code 0010, X=3, Y=4 → out_valid rises 3 cycles after the accept edge, out_data=12; busy=1 throughout.
- Compare sequence:
  - code 1010, X=2, Y=9 → out_we=0, out_data=0, cmp_flag=1;
  - then add 1+1 → cmp_flag stays 1;
  - then code 1011, X=4, Y=5 → cmp_flag=0.
- Backpressure:
  - add result with out_ready=0 for 4 cycles → out_data/out_dest/out_we stable, in_ready=0;
  - then out_ready=1 with in_valid=1 → same-edge handoff, next op enters EXEC.
- Reset mid-op: assert rst_n=0 during EXEC of a multiply → immediately (no clock) out_valid=0, cmp_flag=0, alu_code=1111; after release, state IDLE, in_ready=1.
- NOP: code 1101, X=FFFF_FFFF → out_valid after 1 cycle, out_we=0, out_data=0, cmp_flag unchanged.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Execute stage around the combinational ALU. It registers operands, waits the
// op-dependent latency, captures the result and holds it for writeback.
module alu_exec_stage #(
  parameter int DATA_W  = 32,
  parameter int DEST_W  = 4,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_code,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  input  logic [DEST_W-1:0] in_dest,
  output logic [3:0]        alu_code,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_z,
  input  logic              alu_cmp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_we,
  output logic              cmp_flag,
  output logic              busy
);

  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_LT  = 4'b1010;
  localparam logic [3:0] OP_EQ  = 4'b1011;
  localparam logic [3:0] OP_NOP = 4'b1111;
  localparam int         CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          alu_code_q, alu_code_d;
  logic [DATA_W-1:0]   alu_x_q, alu_x_d;
  logic [DATA_W-1:0]   alu_y_q, alu_y_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [DEST_W-1:0]   out_dest_q, out_dest_d;
  logic                out_we_q, out_we_d;
  logic                cmp_flag_q, cmp_flag_d;

  logic accept;
  logic is_write;
  logic is_cmp;

  assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;
  assign is_write = (alu_code_q <= 4'b1001);
  assign is_cmp   = (alu_code_q == OP_LT) || (alu_code_q == OP_EQ);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_code_d  = alu_code_q;
    alu_x_d     = alu_x_q;
    alu_y_d     = alu_y_q;
    dest_d      = dest_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_dest_d  = out_dest_q;
    out_we_d    = out_we_q;
    cmp_flag_d  = cmp_flag_q;

    unique case (state_q)
      IDLE: ;
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          out_data_d  = is_write ? alu_z : '0;
          out_we_d    = is_write;
          out_dest_d  = dest_q;
          cmp_flag_d  = is_cmp ? alu_cmp : cmp_flag_q;
          out_valid_d = 1'b1;
          alu_code_d  = OP_NOP;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept is only possible from IDLE or a draining HOLD, so it overrides both.
    if (accept) begin
      alu_code_d = in_code;
      alu_x_d    = in_x;
      alu_y_d    = in_y;
      dest_d     = in_dest;
      cnt_d      = (in_code == OP_MUL) ? CNT_W'(MUL_LAT) : '0;
      state_d    = EXEC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_code_q  <= OP_NOP;
      alu_x_q     <= '0;
      alu_y_q     <= '0;
      dest_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_dest_q  <= '0;
      out_we_q    <= 1'b0;
      cmp_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_code_q  <= alu_code_d;
      alu_x_q     <= alu_x_d;
      alu_y_q     <= alu_y_d;
      dest_q      <= dest_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_dest_q  <= out_dest_d;
      out_we_q    <= out_we_d;
      cmp_flag_q  <= cmp_flag_d;
    end
  end

  assign alu_code  = alu_code_q;
  assign alu_x     = alu_x_q;
  assign alu_y     = alu_y_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_dest  = out_dest_q;
  assign out_we    = out_we_q;
  assign cmp_flag  = cmp_flag_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a small behavioural ALU on the
// alu_* side; expected values are hand-computed constants.
module tb_alu_exec_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_code;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic [3:0]  in_dest;
  logic [3:0]  alu_code;
  logic [31:0] alu_x;
  logic [31:0] alu_y;
  logic [31:0] alu_z;
  logic        alu_cmp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_dest;
  logic        out_we;
  logic        cmp_flag;
  logic        busy;

  int checks;
  int failures;

  alu_exec_stage #(.DATA_W(32), .DEST_W(4), .MUL_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .in_x(in_x), .in_y(in_y), .in_dest(in_dest),
    .alu_code(alu_code), .alu_x(alu_x), .alu_y(alu_y),
    .alu_z(alu_z), .alu_cmp(alu_cmp),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dest(out_dest), .out_we(out_we), .cmp_flag(cmp_flag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: non-compare ops drive cmp high and NOP/compare drive a
  // nonzero Z, so a stage that captures them wrongly becomes visible.
  always_comb begin
    alu_cmp = 1'b1;
    unique case (alu_code)
      4'b0000: alu_z = alu_x + alu_y;
      4'b0001: alu_z = alu_x - alu_y;
      4'b0010: alu_z = alu_x * alu_y;
      4'b1010: begin alu_z = alu_x - alu_y; alu_cmp = (alu_x < alu_y); end
      4'b1011: begin alu_z = alu_x ^ alu_y; alu_cmp = (alu_x == alu_y); end
      default: alu_z = alu_x | alu_y | 32'h1;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] code, input logic [31:0] x,
                      input logic [31:0] y, input logic [3:0] dest);
    in_valid = 1'b1;
    in_code  = code;
    in_x     = x;
    in_y     = y;
    in_dest  = dest;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%0h exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_out_data got=%0h exp=0", out_data); end
    checks++; if (out_dest !== 4'h0) begin failures++; $display("[TB] FAIL reset_out_dest got=%0h exp=0", out_dest); end
    checks++; if (out_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_we got=%0h exp=0", out_we); end
    checks++; if (cmp_flag !== 1'b0) begin failures++; $display("[TB] FAIL reset_cmp_flag got=%0h exp=0", cmp_flag); end
    checks++; if (alu_code !== 4'hF) begin failures++; $display("[TB] FAIL reset_alu_code got=%0h exp=f", alu_code); end
    checks++; if (alu_x !== 32'h0 || alu_y !== 32'h0) begin failures++; $display("[TB] FAIL reset_alu_xy got=%0h/%0h exp=0/0", alu_x, alu_y); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_busy_ready got=%0h/%0h exp=0/1", busy, in_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    send(4'b0000, 32'd5, 32'd7, 4'd3);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL add_exec busy/ready/valid got=%0h/%0h/%0h exp=1/0/0", busy, in_ready, out_valid); end
    checks++; if (alu_code !== 4'h0 || alu_x !== 32'd5 || alu_y !== 32'd7) begin failures++; $display("[TB] FAIL add_alu_inputs got=%0h/%0h/%0h exp=0/5/7", alu_code, alu_x, alu_y); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL add_out_valid got=%0h exp=1", out_valid); end
    checks++; if (out_data !== 32'd12) begin failures++; $display("[TB] FAIL add_out_data got=%0h exp=c", out_data); end
    checks++; if (out_dest !== 4'd3 || out_we !== 1'b1) begin failures++; $display("[TB] FAIL add_dest_we got=%0h/%0h exp=3/1", out_dest, out_we); end
    checks++; if (cmp_flag !== 1'b0) begin failures++; $display("[TB] FAIL add_cmp_flag got=%0h exp=0", cmp_flag); end
    checks++; if (alu_code !== 4'hF) begin failures++; $display("[TB] FAIL add_alu_code_nop got=%0h exp=f", alu_code); end
    step();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL add_drain valid/busy got=%0h/%0h exp=0/0", out_valid, busy); end
  endtask

  task automatic test_mul();
    out_ready = 1'b1;
    send(4'b0010, 32'd3, 32'd4, 4'd5);
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL mul_wait%0d valid/busy got=%0h/%0h exp=0/1", i, out_valid, busy); end
      checks++; if (alu_code !== 4'h2 || alu_x !== 32'd3 || alu_y !== 32'd4) begin failures++; $display("[TB] FAIL mul_inputs%0d got=%0h/%0h/%0h exp=2/3/4", i, alu_code, alu_x, alu_y); end
      if (i < 2) step();
    end
    step();
    checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("[TB] FAIL mul_done valid/busy got=%0h/%0h exp=1/1", out_valid, busy); end
    checks++; if (out_data !== 32'd12 || out_dest !== 4'd5 || out_we !== 1'b1) begin failures++; $display("[TB] FAIL mul_result got=%0h/%0h/%0h exp=c/5/1", out_data, out_dest, out_we); end
    step();
  endtask

  task automatic test_compare();
    out_ready = 1'b1;
    send(4'b1010, 32'd2, 32'd9, 4'd1);
    step();
    checks++; if (out_valid !== 1'b1 || out_we !== 1'b0 || out_data !== 32'h0) begin failures++; $display("[TB] FAIL lt_result valid/we/data got=%0h/%0h/%0h exp=1/0/0", out_valid, out_we, out_data); end
    checks++; if (cmp_flag !== 1'b1) begin failures++; $display("[TB] FAIL lt_cmp_flag got=%0h exp=1", cmp_flag); end
    step();
    send(4'b0000, 32'd1, 32'd1, 4'd2);
    step();
    checks++; if (out_data !== 32'd2 || cmp_flag !== 1'b1) begin failures++; $display("[TB] FAIL add_after_lt data/cmp got=%0h/%0h exp=2/1", out_data, cmp_flag); end
    step();
    send(4'b1011, 32'd4, 32'd5, 4'd4);
    checks++; if (cmp_flag !== 1'b1) begin failures++; $display("[TB] FAIL eq_flag_during_exec got=%0h exp=1", cmp_flag); end
    step();
    checks++; if (cmp_flag !== 1'b0 || out_we !== 1'b0) begin failures++; $display("[TB] FAIL eq_cmp/we got=%0h/%0h exp=0/0", cmp_flag, out_we); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send(4'b0000, 32'd10, 32'd20, 4'd7);
    step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 32'd30 || out_dest !== 4'd7 || out_we !== 1'b1) begin failures++; $display("[TB] FAIL hold%0d valid/data/dest/we got=%0h/%0h/%0h/%0h exp=1/1e/7/1", i, out_valid, out_data, out_dest, out_we); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL hold%0d_in_ready got=%0h exp=0", i, in_ready); end
      step();
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_code   = 4'b0000;
    in_x      = 32'd100;
    in_y      = 32'd23;
    in_dest   = 4'd9;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL handoff_in_ready got=%0h exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b1 || alu_x !== 32'd100 || alu_code !== 4'h0) begin failures++; $display("[TB] FAIL handoff_exec valid/busy/x/code got=%0h/%0h/%0h/%0h exp=0/1/64/0", out_valid, busy, alu_x, alu_code); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd123 || out_dest !== 4'd9) begin failures++; $display("[TB] FAIL handoff_result valid/data/dest got=%0h/%0h/%0h exp=1/7b/9", out_valid, out_data, out_dest); end
    step();
  endtask

  task automatic test_reset_mid_op();
    out_ready = 1'b1;
    send(4'b1010, 32'd1, 32'd2, 4'd0);
    step();
    step();
    send(4'b0010, 32'd6, 32'd7, 4'd8);
    checks++; if (busy !== 1'b1 || cmp_flag !== 1'b1) begin failures++; $display("[TB] FAIL midop_pre busy/cmp got=%0h/%0h exp=1/1", busy, cmp_flag); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || cmp_flag !== 1'b0 || alu_code !== 4'hF) begin failures++; $display("[TB] FAIL midop_reset valid/cmp/code got=%0h/%0h/%0h exp=0/0/f", out_valid, cmp_flag, alu_code); end
    #2 rst_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midop_release busy/ready/valid got=%0h/%0h/%0h exp=0/1/0", busy, in_ready, out_valid); end
    repeat (3) step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midop_no_output got=%0h exp=0", out_valid); end
  endtask

  task automatic test_nop();
    out_ready = 1'b1;
    send(4'b1010, 32'd3, 32'd8, 4'd0);
    step();
    step();
    send(4'b1101, 32'hFFFF_FFFF, 32'h0, 4'd6);
    step();
    checks++; if (out_valid !== 1'b1 || out_we !== 1'b0 || out_data !== 32'h0) begin failures++; $display("[TB] FAIL nop valid/we/data got=%0h/%0h/%0h exp=1/0/0", out_valid, out_we, out_data); end
    checks++; if (cmp_flag !== 1'b1 || out_dest !== 4'd6) begin failures++; $display("[TB] FAIL nop cmp/dest got=%0h/%0h exp=1/6", cmp_flag, out_dest); end
    step();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    in_valid  = 1'b0;
    in_code   = 4'hF;
    in_x      = '0;
    in_y      = '0;
    in_dest   = '0;
    out_ready = 1'b0;
    test_reset();
    test_add();
    test_mul();
    test_compare();
    test_back_to_back();
    test_reset_mid_op();
    test_nop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
